uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_tx_drain.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_drain.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_drain
// Description : Serial transmitter that drains a show-ahead FIFO. Each popped
//               word is sent as one start bit (0), WIDTH data bits LSB first,
//               and STOP_BITS stop bits (1). Every bit lasts CLKS_PER_BIT rclk
//               cycles. When the FIFO still holds data during the last stop
//               cycle, the next word is popped in that cycle, so consecutive
//               frames follow with no idle gap.
// Ports       : rclk       - clock, rising edge
//               rst_i      - asynchronous active-high reset
//               en         - permission to start new frames
//               fifo_dat   - FIFO show-ahead data (valid when !fifo_empty)
//               fifo_empty - FIFO empty flag
//               fifo_ren   - FIFO pop strobe (combinational)
//               tx         - serial line, idle high (registered)
//               busy       - frame in progress (registered)
//               frame_done - one-cycle pulse after the last stop cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic             rclk,
    input  logic             rst_i,
    input  logic             en,
    input  logic [WIDTH-1:0] fifo_dat,
    input  logic             fifo_empty,
    output logic             fifo_ren,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int C_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int C_BIT_W  = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;

    localparam logic [C_BAUD_W-1:0] C_BAUD_MAX  = C_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [C_BIT_W-1:0]  C_DATA_LAST = C_BIT_W'(WIDTH - 1);
    localparam logic [C_BIT_W-1:0]  C_STOP_LAST = C_BIT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [C_BAUD_W-1:0] r_baud;
    logic [C_BIT_W-1:0]  r_bitcnt;
    logic [WIDTH-1:0]    r_shift;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [C_BAUD_W-1:0] w_baud_nxt;
    logic [C_BIT_W-1:0]  w_bitcnt_nxt;
    logic [WIDTH-1:0]    w_shift_nxt;
    logic                w_tx_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    logic                w_last_baud;
    logic                w_last_stop;
    logic                w_pop_opp;

    // The baud counter counts down from CLKS_PER_BIT-1; zero marks the last
    // cycle of the current bit. In STOP the bit counter counts stop bits.
    assign w_last_baud = (r_baud == '0);
    assign w_last_stop = (r_state == S_STOP) && w_last_baud && (r_bitcnt == C_STOP_LAST);
    assign w_pop_opp   = (r_state == S_IDLE) || w_last_stop;

    // Reset gates the strobe so no word is popped while the block is held.
    assign fifo_ren = w_pop_opp & en & ~fifo_empty & ~rst_i;

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_tx_nxt     = r_tx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = w_last_stop;

        if (fifo_ren) begin
            // A pop always starts a frame, from IDLE or from the last stop cycle.
            w_state_nxt  = S_START;
            w_baud_nxt   = C_BAUD_MAX;
            w_bitcnt_nxt = '0;
            w_shift_nxt  = fifo_dat;
            w_tx_nxt     = 1'b0;
            w_busy_nxt   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_tx_nxt     = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_baud_nxt   = '0;
                    w_bitcnt_nxt = '0;
                end
                S_START: begin
                    if (w_last_baud) begin
                        w_state_nxt  = S_DATA;
                        w_tx_nxt     = r_shift[0];
                        w_shift_nxt  = r_shift >> 1;
                        w_baud_nxt   = C_BAUD_MAX;
                        w_bitcnt_nxt = '0;
                    end else begin
                        w_baud_nxt = r_baud - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_last_baud) begin
                        w_baud_nxt = C_BAUD_MAX;
                        if (r_bitcnt == C_DATA_LAST) begin
                            w_state_nxt  = S_STOP;
                            w_tx_nxt     = 1'b1;
                            w_bitcnt_nxt = '0;
                        end else begin
                            w_tx_nxt     = r_shift[0];
                            w_shift_nxt  = r_shift >> 1;
                            w_bitcnt_nxt = r_bitcnt + 1'b1;
                        end
                    end else begin
                        w_baud_nxt = r_baud - 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_last_baud) begin
                        if (r_bitcnt == C_STOP_LAST) begin
                            w_state_nxt  = S_IDLE;
                            w_tx_nxt     = 1'b1;
                            w_busy_nxt   = 1'b0;
                            w_baud_nxt   = '0;
                            w_bitcnt_nxt = '0;
                        end else begin
                            w_baud_nxt   = C_BAUD_MAX;
                            w_bitcnt_nxt = r_bitcnt + 1'b1;
                        end
                    end else begin
                        w_baud_nxt = r_baud - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge rclk or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_drain
// Description : Directed bench for uart_tx_drain (WIDTH=8, CLKS_PER_BIT=4).
//               A second instance uses STOP_BITS=2. Each instance reads from
//               a small array-based show-ahead FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_drain;

    logic rclk    = 1'b0;
    logic clk_run = 1'b0;
    logic rst_i   = 1'b0;
    logic en      = 1'b0;
    logic en2     = 1'b0;

    logic [7:0] mem  [0:7];
    logic [7:0] mem2 [0:7];
    int wp = 0, rp = 0, wp2 = 0, rp2 = 0;
    int ren_cnt = 0, ren2_cnt = 0;

    logic [7:0] fifo_dat, fifo_dat2;
    logic       fifo_empty, fifo_empty2;
    logic       fifo_ren, tx, busy, frame_done;
    logic       fifo_ren2, tx2, busy2, frame_done2;

    int checks   = 0;
    int failures = 0;

    assign fifo_empty  = (wp == rp);
    assign fifo_dat    = mem[rp % 8];
    assign fifo_empty2 = (wp2 == rp2);
    assign fifo_dat2   = mem2[rp2 % 8];

    uart_tx_drain #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .rclk       (rclk),
        .rst_i      (rst_i),
        .en         (en),
        .fifo_dat   (fifo_dat),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    uart_tx_drain #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .rclk       (rclk),
        .rst_i      (rst_i),
        .en         (en2),
        .fifo_dat   (fifo_dat2),
        .fifo_empty (fifo_empty2),
        .fifo_ren   (fifo_ren2),
        .tx         (tx2),
        .busy       (busy2),
        .frame_done (frame_done2)
    );

    always begin
        #5;
        if (clk_run) rclk = ~rclk;
    end

    always @(posedge rclk) begin
        if (fifo_ren) begin
            rp      <= rp + 1;
            ren_cnt <= ren_cnt + 1;
        end
        if (fifo_ren2) begin
            rp2      <= rp2 + 1;
            ren2_cnt <= ren2_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp % 8] = d;
        wp = wp + 1;
    endtask

    // Expected line level kk cycles after the pop edge (4 cycles per bit).
    function automatic logic exp_tx(input logic [7:0] w, input int kk);
        int b;
        b = kk / 4;
        if (b == 0) return 1'b0;
        else if (b <= 8) return w[b-1];
        else return 1'b1;
    endfunction

    // Called just after the pop edge (k=0); checks n back-to-back 40-cycle
    // frames and the cycle after the last frame ends.
    task automatic check_frames(input int n, input logic [7:0] w0, input logic [7:0] w1);
        int f, kk;
        for (int k = 0; k <= n * 40; k++) begin
            if (k > 0) tick();
            f  = k / 40;
            kk = k % 40;
            if (k == n * 40) begin
                check_eq($sformatf("end tx k=%0d", k), {31'd0, tx}, 32'd1);
                check_eq($sformatf("end busy k=%0d", k), {31'd0, busy}, 32'd0);
                check_eq($sformatf("end done k=%0d", k), {31'd0, frame_done}, 32'd1);
                check_eq($sformatf("end ren k=%0d", k), {31'd0, fifo_ren}, 32'd0);
            end else begin
                check_eq($sformatf("tx k=%0d", k), {31'd0, tx},
                         {31'd0, exp_tx((f == 0) ? w0 : w1, kk)});
                check_eq($sformatf("busy k=%0d", k), {31'd0, busy}, 32'd1);
                check_eq($sformatf("done k=%0d", k), {31'd0, frame_done},
                         {31'd0, (k > 0 && kk == 0)});
                check_eq($sformatf("ren k=%0d", k), {31'd0, fifo_ren},
                         {31'd0, (kk == 39 && f < n - 1)});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with no clock; FIFO already holds a word and en is high.
        en = 1'b1;
        push(8'hA5);
        mem2[0] = 8'h3C;
        wp2 = 1;
        #2 rst_i = 1'b1;
        #2;
        check_eq("rst tx", {31'd0, tx}, 32'd1);
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst ren", {31'd0, fifo_ren}, 32'd0);
        check_eq("rst done", {31'd0, frame_done}, 32'd0);
        rst_i = 1'b0;
        #1;
        check_eq("ren after rst", {31'd0, fifo_ren}, 32'd1);
        clk_run = 1'b1;

        // Single frame 0xA5.
        tick();
        check_frames(1, 8'hA5, 8'h00);
        tick();
        check_eq("single done clear", {31'd0, frame_done}, 32'd0);
        check_eq("single pops", ren_cnt, 32'd1);

        // Gating: FIFO non-empty, en low.
        en = 1'b0;
        push(8'h00);
        push(8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("gate ren i=%0d", i), {31'd0, fifo_ren}, 32'd0);
            check_eq($sformatf("gate tx i=%0d", i), {31'd0, tx}, 32'd1);
        end
        en = 1'b1;
        #1;
        check_eq("gate ren on en", {31'd0, fifo_ren}, 32'd1);

        // Back-to-back 0x00 then 0xFF.
        tick();
        check_frames(2, 8'h00, 8'hFF);
        tick();
        check_eq("b2b done clear", {31'd0, frame_done}, 32'd0);
        check_eq("b2b pops", ren_cnt, 32'd3);

        // Reset during data bit 3 of 0x53 (bit 3 is 0).
        push(8'h53);
        #1;
        tick();
        for (int k = 1; k <= 17; k++) tick();
        check_eq("pre rst tx", {31'd0, tx}, 32'd0);
        check_eq("pre rst busy", {31'd0, busy}, 32'd1);
        #1 rst_i = 1'b1;
        #1;
        check_eq("mid rst tx", {31'd0, tx}, 32'd1);
        check_eq("mid rst busy", {31'd0, busy}, 32'd0);
        check_eq("mid rst ren", {31'd0, fifo_ren}, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq($sformatf("post rst tx i=%0d", i), {31'd0, tx}, 32'd1);
            check_eq($sformatf("post rst busy i=%0d", i), {31'd0, busy}, 32'd0);
            check_eq($sformatf("post rst ren i=%0d", i), {31'd0, fifo_ren}, 32'd0);
        end
        check_eq("post rst pops", ren_cnt, 32'd4);

        // Two stop bits, 0x3C: 44-cycle frame.
        check_eq("sb2 idle tx", {31'd0, tx2}, 32'd1);
        en2 = 1'b1;
        #1;
        check_eq("sb2 ren", {31'd0, fifo_ren2}, 32'd1);
        tick();
        for (int k = 0; k <= 44; k++) begin
            if (k > 0) tick();
            if (k == 44) begin
                check_eq("sb2 end tx", {31'd0, tx2}, 32'd1);
                check_eq("sb2 end busy", {31'd0, busy2}, 32'd0);
                check_eq("sb2 end done", {31'd0, frame_done2}, 32'd1);
            end else begin
                check_eq($sformatf("sb2 tx k=%0d", k), {31'd0, tx2},
                         {31'd0, exp_tx(8'h3C, k)});
                check_eq($sformatf("sb2 busy k=%0d", k), {31'd0, busy2}, 32'd1);
                check_eq($sformatf("sb2 done k=%0d", k), {31'd0, frame_done2}, 32'd0);
            end
        end
        tick();
        check_eq("sb2 done clear", {31'd0, frame_done2}, 32'd0);
        check_eq("sb2 pops", ren2_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
